core_scheduler: RTL and testbench

//  Per-core control FSM that sequences one block of SIMD threads through

---
 rtl/gpu_pkg.sv | 30 +++
 rtl/core_scheduler.sv | 144 ++++++++++++++
 tb/tb_core_scheduler.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
// Shared GPU core constants: scheduler state encoding, LSU lane state encoding
// and the fetcher handshake value. The ALU and LSU compare against the same names.
package gpu_pkg;

  typedef enum logic [2:0] {
    CS_IDLE    = 3'b000,
    CS_FETCH   = 3'b001,
    CS_DECODE  = 3'b010,
    CS_REQUEST = 3'b011,
    CS_WAIT    = 3'b100,
    CS_EXECUTE = 3'b101,
    CS_UPDATE  = 3'b110,
    CS_DONE    = 3'b111
  } core_state_t;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'b00,
    LSU_REQ  = 2'b01,
    LSU_WAIT = 2'b10,
    LSU_DONE = 2'b11
  } lsu_state_t;

  localparam logic [2:0] FETCHER_FETCHED = 3'b010;

  // A lane holds the core in WAIT while its memory request is outstanding.
  function automatic logic lsu_busy(input logic [1:0] s);
    return (s == LSU_REQ) || (s == LSU_WAIT);
  endfunction

endpackage

// File: rtl/core_scheduler.sv
// Per-core scheduler: steps one block of SIMD threads through
// FETCH/DECODE/REQUEST/WAIT/EXECUTE/UPDATE, owns the shared PC, flags branch
// divergence and LSU hangs, and reports block completion.
module core_scheduler
  import gpu_pkg::*;
#(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int PC_BITS           = 8,
  parameter int WAIT_TIMEOUT      = 255
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        start,
  input  logic [$clog2(THREADS_PER_BLOCK):0]          thread_count,
  input  logic [2:0]                                  fetcher_state,
  input  logic                                        decoded_ret,
  input  logic [THREADS_PER_BLOCK-1:0][1:0]           lsu_state,
  input  logic [THREADS_PER_BLOCK-1:0][PC_BITS-1:0]   next_pc,
  output logic [2:0]                                  core_state,
  output logic [PC_BITS-1:0]                          current_pc,
  output logic                                        done,
  output logic                                        pc_mismatch,
  output logic                                        lsu_timeout
);

  localparam int TC_W  = $clog2(THREADS_PER_BLOCK) + 1;
  localparam int CNT_W = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
  localparam logic [TC_W-1:0]  MAX_THREADS  = TC_W'(THREADS_PER_BLOCK);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(WAIT_TIMEOUT - 1);

  core_state_t                   state, state_next;
  logic [TC_W-1:0]               active_cnt;
  logic [TC_W-1:0]               clamped_cnt;
  logic [CNT_W-1:0]              wait_cnt;
  logic [THREADS_PER_BLOCK-1:0]  active_mask;
  logic                          any_busy;
  logic                          lane_diverged;

  logic load_active, clr_cnt, inc_cnt, load_pc;
  logic set_done, set_mismatch, set_timeout;

  assign core_state  = state;
  assign clamped_cnt = (thread_count > MAX_THREADS) ? MAX_THREADS : thread_count;

  // Lane qualification: only lanes below the launched count take part in WAIT and divergence.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    active_mask   = '0;
    any_busy      = 1'b0;
    lane_diverged = 1'b0;
    for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
      active_mask[i] = (TC_W'(i) < active_cnt);
      if (active_mask[i] && lsu_busy(lsu_state[i]))
        any_busy = 1'b1;
      if (active_mask[i] && (next_pc[i] != next_pc[0]))
        lane_diverged = 1'b1;
    end
  end

  // Next-state and per-state control strobes.
  always_comb begin
    state_next   = state;
    load_active  = 1'b0;
    clr_cnt      = 1'b0;
    inc_cnt      = 1'b0;
    load_pc      = 1'b0;
    set_done     = 1'b0;
    set_mismatch = 1'b0;
    set_timeout  = 1'b0;
    case (state)
      CS_IDLE: begin
        if (start) begin
          load_active = 1'b1;
          if (clamped_cnt == '0) begin
            state_next = CS_DONE;
            set_done   = 1'b1;
          end else begin
            state_next = CS_FETCH;
          end
        end
      end
      CS_FETCH: begin
        if (fetcher_state == FETCHER_FETCHED)
          state_next = CS_DECODE;
      end
      CS_DECODE: state_next = CS_REQUEST;
      CS_REQUEST: begin
        state_next = CS_WAIT;
        clr_cnt    = 1'b1;
      end
      CS_WAIT: begin
        if (any_busy) begin
          if (wait_cnt == TIMEOUT_LAST) begin
            set_timeout = 1'b1;
            set_done    = 1'b1;
            state_next  = CS_DONE;
          end else begin
            inc_cnt = 1'b1;
          end
        end else begin
          state_next = CS_EXECUTE;
        end
      end
      CS_EXECUTE: state_next = CS_UPDATE;
      CS_UPDATE: begin
        // Lane 0 always wins; divergence is only reported.
        set_mismatch = lane_diverged;
        if (decoded_ret) begin
          state_next = CS_DONE;
          set_done   = 1'b1;
        end else begin
          load_pc    = 1'b1;
          state_next = CS_FETCH;
        end
      end
      CS_DONE:   state_next = CS_DONE;
      default:   state_next = CS_IDLE;
    endcase
  end

  // State register and registered datapath; status flags are sticky until reset.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (reset) begin
      state       <= CS_IDLE;
      active_cnt  <= '0;
      wait_cnt    <= '0;
      current_pc  <= '0;
      done        <= 1'b0;
      pc_mismatch <= 1'b0;
      lsu_timeout <= 1'b0;
    end else begin
      state <= state_next;
      if (load_active)  active_cnt  <= clamped_cnt;
      if (clr_cnt)      wait_cnt    <= '0;
      else if (inc_cnt) wait_cnt    <= wait_cnt + 1'b1;
      if (load_pc)      current_pc  <= next_pc[0];
      if (set_done)     done        <= 1'b1;
      if (set_mismatch) pc_mismatch <= 1'b1;
      if (set_timeout)  lsu_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_core_scheduler.sv
// Directed bench for core_scheduler (T=4, PC_BITS=8, WAIT_TIMEOUT=8).
module tb_core_scheduler;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [2:0]       thread_count;
  logic [2:0]       fetcher_state;
  logic             decoded_ret;
  logic [3:0][1:0]  lsu_state;
  logic [3:0][7:0]  next_pc;
  logic [2:0]       core_state;
  logic [7:0]       current_pc;
  logic             done;
  logic             pc_mismatch;
  logic             lsu_timeout;

  int n_cmp = 0;
  int n_bad = 0;

  core_scheduler #(
    .THREADS_PER_BLOCK(4),
    .PC_BITS(8),
    .WAIT_TIMEOUT(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .thread_count(thread_count),
    .fetcher_state(fetcher_state),
    .decoded_ret(decoded_ret),
    .lsu_state(lsu_state),
    .next_pc(next_pc),
    .core_state(core_state),
    .current_pc(current_pc),
    .done(done),
    .pc_mismatch(pc_mismatch),
    .lsu_timeout(lsu_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    start         = 1'b0;
    thread_count  = 3'd4;
    fetcher_state = 3'b010;
    decoded_ret   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      lsu_state[i] = 2'b11;
      next_pc[i]   = 8'd0;
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic launch(input logic [2:0] tc);
    thread_count = tc;
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  // Reset values, then one full non-memory instruction.
  task automatic test_reset_launch();
    logic [2:0] exp_seq [6];
    exp_seq = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110};
    do_reset();
    n_cmp++;
    if ({core_state, current_pc, done, pc_mismatch, lsu_timeout} !== 14'h0) begin
      n_bad++;
      $display("FAIL reset_values got state=%0h pc=%0h done=%b mm=%b to=%b exp all zero",
               core_state, current_pc, done, pc_mismatch, lsu_timeout);
    end
    for (int i = 0; i < 4; i++) next_pc[i] = 8'd1;
    launch(3'd4);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) tick();
      n_cmp++;
      if (core_state !== exp_seq[k]) begin
        n_bad++;
        $display("FAIL launch_seq[%0d] got=%0h exp=%0h", k, core_state, exp_seq[k]);
      end
    end
    n_cmp++;
    if (current_pc !== 8'd0) begin
      n_bad++;
      $display("FAIL launch_pc_before got=%0d exp=0", current_pc);
    end
    tick();
    n_cmp++;
    if (core_state !== 3'b001 || current_pc !== 8'd1) begin
      n_bad++;
      $display("FAIL launch_pc_after got state=%0h pc=%0d exp state=1 pc=1", core_state, current_pc);
    end
  endtask

  // Lane 2 busy for 5 cycles starting in REQUEST; WAIT visible for exactly 5 cycles.
  task automatic test_mem_stall();
    int waits;
    for (int i = 0; i < 4; i++) next_pc[i] = 8'd2;
    tick();                       // DECODE
    tick();                       // REQUEST
    lsu_state[2] = 2'b10;
    waits = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (core_state == 3'b100) waits++;
    end
    lsu_state[2] = 2'b11;
    n_cmp++;
    if (waits != 5) begin
      n_bad++;
      $display("FAIL stall_wait_cycles got=%0d exp=5", waits);
    end
    tick();
    n_cmp++;
    if (core_state !== 3'b101) begin
      n_bad++;
      $display("FAIL stall_exit got=%0h exp=5", core_state);
    end
    tick();
    tick();
    n_cmp++;
    if (core_state !== 3'b001 || current_pc !== 8'd2) begin
      n_bad++;
      $display("FAIL stall_pc got state=%0h pc=%0d exp state=1 pc=2", core_state, current_pc);
    end
  endtask

  // Two active lanes; lane 3 stuck busy and divergent must be ignored.
  task automatic test_partial_block();
    do_reset();
    next_pc      = {8'd9, 8'd4, 8'd4, 8'd4};
    lsu_state[3] = 2'b10;
    launch(3'd2);
    tick(); tick(); tick();       // DECODE, REQUEST, WAIT
    tick();
    n_cmp++;
    if (core_state !== 3'b101) begin
      n_bad++;
      $display("FAIL partial_no_stall got=%0h exp=5", core_state);
    end
    tick(); tick();
    n_cmp++;
    if (current_pc !== 8'd4 || pc_mismatch !== 1'b0) begin
      n_bad++;
      $display("FAIL partial_update got pc=%0d mm=%b exp pc=4 mm=0", current_pc, pc_mismatch);
    end
    lsu_state[3] = 2'b11;
  endtask

  // Divergent next_pc, sticky flag, then RET termination with start ignored.
  task automatic test_divergence_ret();
    do_reset();
    next_pc = {8'd5, 8'd7, 8'd5, 8'd5};    // lane 2 diverges
    launch(3'd4);
    repeat (6) tick();
    n_cmp++;
    if (current_pc !== 8'd5 || pc_mismatch !== 1'b1) begin
      n_bad++;
      $display("FAIL diverge got pc=%0d mm=%b exp pc=5 mm=1", current_pc, pc_mismatch);
    end
    for (int i = 0; i < 4; i++) next_pc[i] = 8'd6;
    repeat (6) tick();
    n_cmp++;
    if (current_pc !== 8'd6 || pc_mismatch !== 1'b1) begin
      n_bad++;
      $display("FAIL diverge_sticky got pc=%0d mm=%b exp pc=6 mm=1", current_pc, pc_mismatch);
    end
    for (int i = 0; i < 4; i++) next_pc[i] = 8'd9;
    decoded_ret = 1'b1;
    repeat (6) tick();
    decoded_ret = 1'b0;
    n_cmp++;
    if (core_state !== 3'b111 || done !== 1'b1 || current_pc !== 8'd6) begin
      n_bad++;
      $display("FAIL ret_done got state=%0h done=%b pc=%0d exp state=7 done=1 pc=6",
               core_state, done, current_pc);
    end
    start = 1'b1;
    tick(); tick();
    start = 1'b0;
    n_cmp++;
    if (core_state !== 3'b111 || done !== 1'b1 || pc_mismatch !== 1'b1) begin
      n_bad++;
      $display("FAIL done_holds got state=%0h done=%b mm=%b exp 7/1/1", core_state, done, pc_mismatch);
    end
  endtask

  // thread_count=0 finishes immediately; thread_count=7 clamps to 4 (lane 3 active).
  task automatic test_thread_count_edges();
    do_reset();
    launch(3'd0);
    n_cmp++;
    if (core_state !== 3'b111 || done !== 1'b1) begin
      n_bad++;
      $display("FAIL zero_threads got state=%0h done=%b exp state=7 done=1", core_state, done);
    end
    do_reset();
    next_pc      = {8'd3, 8'd2, 8'd2, 8'd2};
    lsu_state[3] = 2'b01;
    launch(3'd7);
    tick(); tick(); tick();       // DECODE, REQUEST, WAIT
    tick();
    n_cmp++;
    if (core_state !== 3'b100) begin
      n_bad++;
      $display("FAIL clamp_lane3_busy got=%0h exp=4", core_state);
    end
    lsu_state[3] = 2'b11;
    tick(); tick(); tick();       // EXECUTE, UPDATE, FETCH
    n_cmp++;
    if (current_pc !== 8'd2 || pc_mismatch !== 1'b1) begin
      n_bad++;
      $display("FAIL clamp_lane3_diverge got pc=%0d mm=%b exp pc=2 mm=1", current_pc, pc_mismatch);
    end
  endtask

  // WAIT timeout after 8 cycles, then async reset mid-WAIT.
  task automatic test_timeout_reset();
    int waits;
    do_reset();
    lsu_state[0] = 2'b01;
    launch(3'd4);
    tick(); tick(); tick();       // DECODE, REQUEST, WAIT
    waits = 0;
    for (int k = 0; k < 20 && core_state == 3'b100; k++) begin
      waits++;
      tick();
    end
    n_cmp++;
    if (waits != 8) begin
      n_bad++;
      $display("FAIL timeout_wait_cycles got=%0d exp=8", waits);
    end
    n_cmp++;
    if (core_state !== 3'b111 || lsu_timeout !== 1'b1 || done !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_flags got state=%0h to=%b done=%b exp 7/1/1", core_state, lsu_timeout, done);
    end
    // Build up non-reset state, then stall and reset between clock edges.
    do_reset();
    next_pc = {8'd3, 8'd3, 8'd8, 8'd3};
    launch(3'd4);
    repeat (6) tick();
    lsu_state[0] = 2'b10;
    tick(); tick(); tick();       // DECODE, REQUEST, WAIT
    n_cmp++;
    if (core_state !== 3'b100 || current_pc !== 8'd3 || pc_mismatch !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset got state=%0h pc=%0d mm=%b exp 4/3/1", core_state, current_pc, pc_mismatch);
    end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({core_state, current_pc, done, pc_mismatch, lsu_timeout} !== 14'h0) begin
      n_bad++;
      $display("FAIL async_reset got state=%0h pc=%0d done=%b mm=%b to=%b exp all zero",
               core_state, current_pc, done, pc_mismatch, lsu_timeout);
    end
    @(negedge clk);
    reset        = 1'b0;
    lsu_state[0] = 2'b11;
  endtask

  initial begin
    reset         = 1'b1;
    start         = 1'b0;
    thread_count  = 3'd0;
    fetcher_state = 3'b000;
    decoded_ret   = 1'b0;
    lsu_state     = '0;
    next_pc       = '0;
    test_reset_launch();
    test_mem_stall();
    test_partial_block();
    test_divergence_ret();
    test_thread_count_edges();
    test_timeout_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
